// File: rtl/alu_bcd_converter_pkg.sv
// rtl/alu_bcd_converter_pkg.sv - shared constants and state encoding for the ALU result BCD converter
package alu_bcd_converter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_W     = 4;
    localparam int DEFAULT_W = 8;

endpackage

// File: rtl/alu_bcd_converter_bcd_add3.sv
// rtl/alu_bcd_converter_bcd_add3.sv - double-dabble digit correction cell (add 3 when digit >= 5)
module bcd_add3
    import alu_bcd_converter_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;

endmodule

// File: rtl/alu_bcd_converter.sv
// rtl/alu_bcd_converter.sv - sequential double-dabble conversion of a signed/unsigned ALU result to sign + 3 BCD digits
module alu_bcd_converter
    import alu_bcd_converter_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             BTN0,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic             neg,
    output logic [BCD_W-1:0] hundreds,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] units
);

    localparam int CNT_W = $clog2(W + 1);
    localparam int SR_W  = 3 * BCD_W + W + 1;

    state_t             state_q, state_d;
    logic               accept, finish;
    logic [CNT_W-1:0]   cnt_q;
    logic [W:0]         mag_q;
    logic [BCD_W-1:0]   hun_q, ten_q, uni_q;
    logic [BCD_W-1:0]   hun_c, ten_c, uni_c;
    logic               neg_q;
    logic               sign_in;
    logic [W:0]         bin_ext;
    logic [W:0]         abs_in;
    logic [SR_W-1:0]    sr_c;

    assign sign_in = SIGNED && bin[W-1];
    assign bin_ext = {bin[W-1] & SIGNED, bin};
    assign abs_in  = sign_in ? (~bin_ext + {{W{1'b0}}, 1'b1}) : bin_ext;

    bcd_add3 u_add3_hun (.din(hun_q), .dout(hun_c));
    bcd_add3 u_add3_ten (.din(ten_q), .dout(ten_c));
    bcd_add3 u_add3_uni (.din(uni_q), .dout(uni_c));

    // mag_q holds the magnitude pre-shifted by one: the capture edge performs the
    // first (correction-free) shift so W edges cover all W+1 magnitude bits.
    assign sr_c = {hun_c, ten_c, uni_c, mag_q} << 1;

    always_ff @(posedge clk) begin
        if (!BTN0) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    accept  = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SHIFT);

    always_ff @(posedge clk) begin
        if (!BTN0) begin
            cnt_q    <= '0;
            mag_q    <= '0;
            hun_q    <= '0;
            ten_q    <= '0;
            uni_q    <= '0;
            neg_q    <= 1'b0;
            done     <= 1'b0;
            neg      <= 1'b0;
            hundreds <= '0;
            tens     <= '0;
            units    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                cnt_q <= '0;
                mag_q <= {abs_in[W-1:0], 1'b0};
                hun_q <= '0;
                ten_q <= '0;
                uni_q <= {{(BCD_W-1){1'b0}}, abs_in[W]};
                neg_q <= sign_in;
            end else if (state_q == SHIFT) begin
                cnt_q <= cnt_q + CNT_W'(1);
                mag_q <= sr_c[W:0];
                uni_q <= sr_c[W+BCD_W:W+1];
                ten_q <= sr_c[W+2*BCD_W:W+BCD_W+1];
                hun_q <= sr_c[W+3*BCD_W:W+2*BCD_W+1];
                if (finish) begin
                    units    <= sr_c[W+BCD_W:W+1];
                    tens     <= sr_c[W+2*BCD_W:W+BCD_W+1];
                    hundreds <= sr_c[W+3*BCD_W:W+2*BCD_W+1];
                    neg      <= neg_q;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_bcd_converter.sv
// tb/tb_alu_bcd_converter.sv - self-checking bench for alu_bcd_converter (signed and unsigned instances)
module tb_alu_bcd_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            BTN0;
    logic [1:0]      start_v;
    logic [1:0][7:0] bin_v;
    logic [1:0]      busy_v, done_v, neg_v;
    logic [1:0][3:0] hun_v, ten_v, uni_v;

    alu_bcd_converter #(.W(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .BTN0(BTN0), .start(start_v[0]), .bin(bin_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .neg(neg_v[0]),
        .hundreds(hun_v[0]), .tens(ten_v[0]), .units(uni_v[0])
    );

    alu_bcd_converter #(.W(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .BTN0(BTN0), .start(start_v[1]), .bin(bin_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .neg(neg_v[1]),
        .hundreds(hun_v[1]), .tens(ten_v[1]), .units(uni_v[1])
    );

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   done_cnt [2];

    // Reference: a conversion is a countdown of 8 edges, the answer is plain decimal arithmetic.
    int         m_rem [2];
    int         m_val [2];
    bit         m_neg [2];
    logic [1:0] e_busy, e_done, e_neg;
    int         e_h [2], e_t [2], e_u [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!BTN0) begin
                m_rem[i]  = 0;
                e_busy[i] = 1'b0;
                e_done[i] = 1'b0;
                e_neg[i]  = 1'b0;
                e_h[i]    = 0;
                e_t[i]    = 0;
                e_u[i]    = 0;
            end else begin
                e_done[i] = 1'b0;
                if (m_rem[i] > 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        e_done[i] = 1'b1;
                        e_neg[i]  = m_neg[i];
                        e_h[i]    = m_val[i] / 100;
                        e_t[i]    = (m_val[i] / 10) % 10;
                        e_u[i]    = m_val[i] % 10;
                    end
                end else if (start_v[i]) begin
                    m_neg[i] = (i == 0) && bin_v[i][7];
                    m_val[i] = m_neg[i] ? 256 - int'(bin_v[i]) : int'(bin_v[i]);
                    m_rem[i] = 8;
                end
                e_busy[i] = (m_rem[i] > 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic [14:0] act, exp;
                act = {busy_v[i], done_v[i], neg_v[i], hun_v[i], ten_v[i], uni_v[i]};
                exp = {e_busy[i], e_done[i], e_neg[i], 4'(e_h[i]), 4'(e_t[i]), 4'(e_u[i])};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL cycle_cmp dut%0d t=%0t: got busy=%b done=%b neg=%b digits=%h%h%h, expected busy=%b done=%b neg=%b digits=%h%h%h",
                             i, $time, act[14], act[13], act[12], act[11:8], act[7:4], act[3:0],
                             exp[14], exp[13], exp[12], exp[11:8], exp[7:4], exp[3:0]);
                end
                if (done_v[i] === 1'b1) done_cnt[i]++;
            end
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_result(input int i, input string tag, input int n, input int h, input int t, input int u);
        check_val({tag, "_neg"}, int'(neg_v[i]), n);
        check_val({tag, "_hundreds"}, int'(hun_v[i]), h);
        check_val({tag, "_tens"}, int'(ten_v[i]), t);
        check_val({tag, "_units"}, int'(uni_v[i]), u);
        check_val({tag, "_model_digits"}, e_h[i] * 100 + e_t[i] * 10 + e_u[i], h * 100 + t * 10 + u);
        check_val({tag, "_model_neg"}, int'(e_neg[i]), n);
    endtask

    task automatic start_only(input int i, input logic [7:0] b);
        @(negedge clk);
        bin_v[i]   = b;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
    endtask

    // Entered 1 time unit after the start-sampling edge; returns edges until done.
    task automatic wait_done(input int i, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = int'(busy_v[i]);
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!done_v[i] && busy_v[i]) busy_cnt++;
        end while (!done_v[i] && lat < 40);
        check_val("done_seen", int'(done_v[i]), 1);
    endtask

    initial begin
        int lat, bc, dc;
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        m_rem[0] = 0; m_rem[1] = 0;
        BTN0    = 1'b0;
        start_v = 2'b11;
        bin_v[0] = 8'h00;
        bin_v[1] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check_val("reset_outputs", int'({busy_v[0], done_v[0], neg_v[0], hun_v[0], ten_v[0], uni_v[0]}), 0);

        // Release reset with start already high: zero converts to 0,0,0 positive.
        @(negedge clk);
        BTN0 = 1'b1;
        @(posedge clk);
        #1;
        start_v = 2'b00;
        wait_done(0, lat, bc);
        check_val("zero_latency", lat, 8);
        expect_result(0, "zero", 0, 0, 0, 0);

        start_only(0, 8'h2A);
        wait_done(0, lat, bc);
        check_val("h2a_latency", lat, 8);
        check_val("h2a_busy_cycles", bc, 8);
        expect_result(0, "h2a", 0, 0, 4, 2);

        start_only(0, 8'hF6);
        wait_done(0, lat, bc);
        expect_result(0, "hf6", 1, 0, 1, 0);

        start_only(0, 8'h80);
        wait_done(0, lat, bc);
        expect_result(0, "h80", 1, 1, 2, 8);

        start_only(1, 8'hFF);
        wait_done(1, lat, bc);
        check_val("uff_latency", lat, 8);
        expect_result(1, "uff", 0, 2, 5, 5);

        // A second start while busy must be dropped.
        dc = done_cnt[0];
        start_only(0, 8'h63);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bin_v[0]   = 8'h05;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        wait_done(0, lat, bc);
        expect_result(0, "h63", 0, 0, 9, 9);
        repeat (20) @(posedge clk);
        #1;
        check_val("ignored_start_done_count", done_cnt[0] - dc, 1);

        // Reset on the 4th shift edge aborts the conversion.
        start_only(0, 8'h55);
        repeat (3) @(posedge clk);
        #1;
        BTN0 = 1'b0;
        @(posedge clk);
        #1;
        BTN0 = 1'b1;
        check_val("abort_outputs", int'({busy_v[0], done_v[0], neg_v[0], hun_v[0], ten_v[0], uni_v[0]}), 0);
        dc = done_cnt[0];
        repeat (12) @(posedge clk);
        #1;
        check_val("abort_no_done", done_cnt[0] - dc, 0);
        start_only(0, 8'h07);
        wait_done(0, lat, bc);
        check_val("after_abort_latency", lat, 8);
        expect_result(0, "h07", 0, 0, 0, 7);

        // Start held in the done cycle is accepted immediately.
        start_only(0, 8'h0C);
        wait_done(0, lat, bc);
        expect_result(0, "h0c", 0, 0, 1, 2);
        bin_v[0]   = 8'hE7;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, lat, bc);
        check_val("back_to_back_latency", lat, 8);
        expect_result(0, "he7", 1, 0, 2, 5);

        repeat (600) begin
            @(negedge clk);
            start_v[0] = ($urandom_range(0, 3) == 0);
            start_v[1] = ($urandom_range(0, 3) == 0);
            bin_v[0]   = 8'($urandom);
            bin_v[1]   = 8'($urandom);
            BTN0       = ($urandom_range(0, 63) != 0);
        end
        @(negedge clk);
        BTN0    = 1'b1;
        start_v = 2'b00;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
